// File: rtl/cv32e41s_div_radix.sv
// Iterative radix-2/radix-4 integer divider for RISC-V DIV/DIVU/REM/REMU with early termination.
// Optional result cache enabled by defining CV32E41S_DIV_REUSE_EN.
module cv32e41s_div_radix #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       operator_i,
    input  logic             data_ind_timing_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW    = $clog2(WIDTH + 1);
    localparam int STEPS = WIDTH / BPC;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, DUMMY, FINISH} state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic             sign_a_q;
    logic             neg_quot_q;
    logic             div_zero_q;
    logic             ovf_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    need_q;
    logic             mask_q;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic             ovf;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [CW-1:0]    clz_b;
    logic [CW:0]      n_bits;
    logic [CW:0]      k_bits;
    logic [CW-1:0]    need_var;
    logic [CW-1:0]    cnt_init;
    logic             mask_init;
    logic [WIDTH-1:0] dvs_init;

    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] dvs_n;
    logic [WIDTH-1:0] quo_n;
    logic             ge;

    logic             hit;
    logic [WIDTH-1:0] hit_quo;
    logic [WIDTH-1:0] hit_rem;

    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;

    function automatic logic [CW-1:0] clz(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        logic          found;
        n     = CW'(WIDTH);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = CW'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    always_comb begin
        is_signed = ~operator_i[0];
        a_neg     = is_signed & op_a_i[WIDTH-1];
        b_neg     = is_signed & op_b_i[WIDTH-1];
        b_zero    = (op_b_i == '0);
        ovf       = is_signed & (op_a_i == MIN_VAL) & (op_b_i == '1);
        abs_a     = a_neg ? ('0 - op_a_i) : op_a_i;
        abs_b     = b_neg ? ('0 - op_b_i) : op_b_i;
        clz_b     = clz(abs_b);
        dvs_init  = abs_b << clz_b;
        n_bits    = {1'b0, clz_b} + (CW+1)'(1);
        k_bits    = (BPC == 2) ? ((n_bits + (CW+1)'(1)) >> 1) : n_bits;
        need_var  = b_zero ? CW'(1) : k_bits[CW-1:0];
        cnt_init  = data_ind_timing_i ? CW'(STEPS) : need_var;
        // With two bits per cycle and an odd bit count, the first step is skipped
        mask_init = (BPC == 2) && !b_zero && n_bits[0];
    end

    // BPC restoring steps against the aligned divisor; a masked step passes values through
    always_comb begin
        rem_n = rem_q;
        dvs_n = dvs_q;
        quo_n = quo_q;
        ge    = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            if (i != 0 || !mask_q) begin
                ge = (rem_n >= dvs_n);
                if (ge) begin
                    rem_n = rem_n - dvs_n;
                end
                quo_n = {quo_n[WIDTH-2:0], ge};
                dvs_n = dvs_n >> 1;
            end
        end
    end

`ifdef CV32E41S_DIV_REUSE_EN
    logic             cache_valid_q;
    logic             cache_signed_q;
    logic [WIDTH-1:0] cache_a_q;
    logic [WIDTH-1:0] cache_b_q;
    logic [WIDTH-1:0] cache_quo_q;
    logic [WIDTH-1:0] cache_rem_q;

    assign hit = cache_valid_q && !data_ind_timing_i && (op_a_i == cache_a_q)
                 && (op_b_i == cache_b_q) && (is_signed == cache_signed_q);
    assign hit_quo = cache_quo_q;
    assign hit_rem = cache_rem_q;

    // Key is captured at accept but only becomes valid once that operation retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid_q  <= 1'b0;
            cache_signed_q <= 1'b0;
            cache_a_q      <= '0;
            cache_b_q      <= '0;
            cache_quo_q    <= '0;
            cache_rem_q    <= '0;
        end else if (state_q != IDLE && !valid_i) begin
            cache_valid_q <= 1'b0;
        end else if (state_q == IDLE && valid_i && !hit) begin
            cache_valid_q  <= 1'b0;
            cache_signed_q <= is_signed;
            cache_a_q      <= op_a_i;
            cache_b_q      <= op_b_i;
        end else if (state_q == FINISH && ready_i) begin
            cache_valid_q <= 1'b1;
            cache_quo_q   <= quo_q;
            cache_rem_q   <= rem_q;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_quo = '0;
    assign hit_rem = '0;
`endif

    // need_q counts real iterations, cnt_q counts every DIVIDE and DUMMY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            sign_a_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            rem_q      <= '0;
            dvs_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            need_q     <= '0;
            mask_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q       <= operator_i;
                        sign_a_q   <= a_neg;
                        neg_quot_q <= (a_neg ^ b_neg) & ~b_zero;
                        div_zero_q <= b_zero;
                        ovf_q      <= ovf;
                        if (hit) begin
                            rem_q   <= hit_rem;
                            quo_q   <= hit_quo;
                            dvs_q   <= '0;
                            cnt_q   <= '0;
                            need_q  <= '0;
                            mask_q  <= 1'b0;
                            state_q <= FINISH;
                        end else begin
                            rem_q   <= abs_a;
                            dvs_q   <= dvs_init;
                            quo_q   <= '0;
                            cnt_q   <= cnt_init;
                            need_q  <= need_var;
                            mask_q  <= mask_init;
                            state_q <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (!valid_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q  <= rem_n;
                        dvs_q  <= dvs_n;
                        quo_q  <= quo_n;
                        mask_q <= 1'b0;
                        cnt_q  <= cnt_q - CW'(1);
                        need_q <= need_q - CW'(1);
                        if (need_q == CW'(1)) begin
                            state_q <= (cnt_q == CW'(1)) ? FINISH : DUMMY;
                        end
                    end
                end
                DUMMY: begin
                    if (!valid_i) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    if (!valid_i || ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A zero divisor never changes the remainder register, so it already holds |a|
    always_comb begin
        if (div_zero_q) begin
            quo_res = '1;
        end else if (ovf_q) begin
            quo_res = MIN_VAL;
        end else begin
            quo_res = neg_quot_q ? ('0 - quo_q) : quo_q;
        end
        if (ovf_q) begin
            rem_res = '0;
        end else begin
            rem_res = sign_a_q ? ('0 - rem_q) : rem_q;
        end
    end

    assign valid_o  = (state_q == FINISH) && valid_i;
    assign ready_o  = rst_n && (!valid_i || ((state_q == FINISH) && ready_i));
    assign result_o = (state_q == FINISH) ? (op_q[1] ? rem_res : quo_res) : '0;

endmodule

// File: doc/cv32e41s_div_radix.md
Name: cv32e41s_div_radix

Overview:
- Parametrised iterative integer divider; next generation of the core's serial divider.
- Self-contained: internal leading-zero count and divisor alignment, no ALU CLZ/shifter sharing.
- Configurable width and radix (1 or 2 quotient bits per cycle).
- Supports RISC-V DIV/DIVU/REM/REMU semantics, early termination, optional data-independent timing, valid/ready handshakes and kill. Sits in the EX stage beside the multiplier.

Parameters:
- WIDTH, 32, operand/result width; legal 8..64, even.
- BPC, 1, quotient bits retired per DIVIDE cycle; legal 1 or 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- operator_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept only.
- data_ind_timing_i  in  1  force fixed latency; sampled at accept.
- op_a_i  in  WIDTH  dividend; sampled at accept.
- op_b_i  in  WIDTH  divisor; sampled at accept.
- valid_i  in  1  request valid; deassertion = kill.
- ready_o  out  1  accept/retire indication.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream ready.
- result_o  out  WIDTH  quotient or remainder.

Behaviour:
- Reset: state IDLE, all registers 0; valid_o=0, ready_o=0 while valid_i=0 in reset, result_o=0.
- States: IDLE, DIVIDE, DUMMY, FINISH.
- IDLE & valid_i (accept, cycle 0):
  - Latch operator, data_ind_timing_i, magnitudes |a|, |b| (signed ops only), sign flags.
  - Compute clz(|b|) (WIDTH if zero).
  - Load divisor = |b| << clz, remainder = |a|, quotient = 0.
  - Set counter K:
    - variable mode: K = ceil((clz+1)/BPC), capped at WIDTH/BPC; K=1 if divisor zero.
    - data_ind mode: K = WIDTH/BPC always.
  - Go DIVIDE.
- DIVIDE: each cycle performs BPC restoring steps (compare, conditional subtract, shift divisor right 1, shift quotient left 1 with compare bit), decrement counter.
  - Last variable-mode iteration → FINISH.
  - In data_ind mode, iterations beyond the needed count are performed via DUMMY state, which holds datapath registers unchanged and only counts; total cycles identical.
  - K counts DIVIDE+DUMMY cycles.
  - BPC=2 with odd needed bit count: first step masked so exactly clz+1 bits are produced.
- FINISH: valid_o=1; result_o = quotient or remainder, sign-corrected.
  - Quotient is negated if sign(a)≠sign(b) and b≠0.
  - Remainder takes the sign of a.
  - ready_i=1 → ready_o=1, return IDLE. ready_i=0 → hold, result_o stable.
- Latency: valid_o first high at cycle K+1 after accept.
- Special results, forced regardless of datapath:
  - Divide by zero: quotient all ones, remainder = a.
  - Signed overflow (a = MIN, b = −1): quotient MIN, remainder 0.
  - Special results do not shorten data_ind latency.
- Kill: valid_i=0 in any state → next state IDLE, ready_o=1, valid_o=0 same cycle. Datapath contents are don't-care. Accept of a new op possible the cycle valid_i returns.
- ready_o=0 in IDLE-accept, DIVIDE, DUMMY, and FINISH with ready_i=0.
- No back-to-back accept from FINISH; the next op is accepted in IDLE.

Optional Feature:
- Macro CV32E41S_DIV_REUSE_EN.
- Defined:
  - Keep last completed |a|, |b|, signedness, final quotient and remainder in a result cache.
  - Accept with identical op_a_i, op_b_i and signedness, and data_ind_timing_i=0 → skip DIVIDE, go straight to FINISH (valid_o at cycle 1).
  - Cache invalidated by kill and reset.
- Undefined: no cache registers; every op follows normal latency.

Test Plan:
- DIVU 100/7, WIDTH=32, BPC=1, data_ind=0 → result 14, valid_o at cycle 31 (clz=29, K=30); REMU same operands → 2.
- Same with data_ind=1 → 14, valid_o at cycle 33; DIVU 0xFFFFFFFF/1 data_ind=1 also cycle 33.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIV 7/−2 → 0xFFFFFFFD; REM 7/−2 → 1.
- DIVU 0x1234/0 → 0xFFFFFFFF at cycle 2; REM 0x1234/0 → 0x1234; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- BPC=2: DIVU 1000/3 → 333, valid_o at cycle 17 (clz=30, K=16); hold ready_i=0 five cycles → result_o stable, valid_o high throughout.
- Kill: drop valid_i at cycle 10 of DIVU 100/7 → ready_o=1, valid_o=0 that cycle; next accept of DIVU 9/3 → 3. With CV32E41S_DIV_REUSE_EN: repeat REMU 100/7 after completion → 2 at cycle 1.
